// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin tri-state bus arbiter with turnaround gap and hold timeout
module bus_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int OWNER_W  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    oe,
  output logic               bus_busy,
  output logic [OWNER_W-1:0] owner,
  output logic               preempt
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [OWNER_W:0]   NREQ_X    = (OWNER_W + 1)'(NREQ);
  localparam logic [OWNER_W-1:0] LAST_IDX  = OWNER_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [OWNER_W-1:0]  ptr, ptr_nxt;
  logic [OWNER_W-1:0]  owner_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [NREQ-1:0]     gnt_nxt;
  logic                preempt_nxt;

  logic [NREQ-1:0]     rot;
  logic [OWNER_W:0]    win_sum;
  logic [OWNER_W-1:0]  win;
  logic                win_vld;
  logic [NREQ-1:0]     win_oh;
  logic [NREQ-1:0]     owner_oh;
  logic                owner_req;
  logic                others;
  logic                timeout;
  logic [OWNER_W-1:0]  ptr_after;

  // Rotate so bit 0 is the device at ptr; the first set bit is the winner.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    win_vld = 1'b0;
    win_sum = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!win_vld && rot[j]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, ptr} + (OWNER_W + 1)'(j);
      end
    end
    if (win_sum >= NREQ_X) begin
      win_sum = win_sum - NREQ_X;
    end
    win = win_sum[OWNER_W-1:0];
  end

  assign win_oh    = NREQ'(1) << win;
  assign owner_oh  = NREQ'(1) << owner;
  assign owner_req = |(req & owner_oh);
  assign others    = |(req & ~owner_oh);
  assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign ptr_after = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    preempt_nxt = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (win_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = win_oh;
          owner_nxt = win;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      GRANT: begin
        // A voluntary release wins over a timeout on the same cycle.
        if (!owner_req) begin
          state_nxt = TURN;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after;
        end else if (timeout && others) begin
          state_nxt   = TURN;
          gnt_nxt     = '0;
          ptr_nxt     = ptr_after;
          preempt_nxt = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      oe       <= '0;
      bus_busy <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      oe       <= gnt_nxt;
      bus_busy <= (state_nxt == GRANT);
      preempt  <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

  localparam int NREQ     = 4;
  localparam int OWNER_W  = 2;
  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = NREQ * (MAX_HOLD + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    oe;
  logic               bus_busy;
  logic [OWNER_W-1:0] owner;
  logic               preempt;

  int checks = 0;
  int errors = 0;

  bus_rr_arbiter #(.NREQ(NREQ), .OWNER_W(OWNER_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .oe       (oe),
    .bus_busy (bus_busy),
    .owner    (owner),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: who holds the bus, how many cycles they have held it, and where the next search begins.
  bit m_busy;
  bit m_preempt;
  int m_owner;
  int m_ptr;
  int m_held;
  int m_wait [NREQ];

  always @(posedge clk or negedge rst) begin
    bit others;
    int c;
    if (!rst) begin
      m_busy    = 1'b0;
      m_preempt = 1'b0;
      m_owner   = 0;
      m_ptr     = 0;
      m_held    = 0;
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !(m_busy && m_owner == i)) m_wait[i]++;
        else m_wait[i] = 0;
        check("starvation", (m_wait[i] > WAIT_MAX), 0);
      end
      if (m_busy) begin
        others = 1'b0;
        for (int i = 0; i < NREQ; i++) if (i != m_owner && req[i]) others = 1'b1;
        if (!req[m_owner]) begin
          m_busy    = 1'b0;
          m_preempt = 1'b0;
          m_ptr     = (m_owner + 1) % NREQ;
        end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && others) begin
          m_busy    = 1'b0;
          m_preempt = 1'b1;
          m_ptr     = (m_owner + 1) % NREQ;
        end else begin
          m_held++;
        end
      end else begin
        m_preempt = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (!m_busy && req[c]) begin
            m_busy  = 1'b1;
            m_owner = c;
            m_held  = 1;
          end
        end
      end
    end
  end

  logic [NREQ-1:0] prev_oe = '0;
  logic [NREQ-1:0] exp_g;

  always @(negedge clk) begin
    if (rst) begin
      exp_g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      check("gnt", gnt, exp_g);
      check("oe", oe, exp_g);
      check("bus_busy", bus_busy, m_busy);
      check("owner", owner, m_owner);
      check("preempt", preempt, m_preempt);
      check("oe_onehot", ($countones(oe) <= 1), 1);
      check("gnt_eq_oe", (gnt == oe), 1);
      check("turn_gap", (prev_oe != 0 && oe != 0 && prev_oe != oe), 0);
      prev_oe = oe;
    end else begin
      prev_oe = '0;
    end
  end

  initial begin
    rst = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_oe", oe, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_owner", owner, 0);
    check("rst_preempt", preempt, 0);
    rst = 1'b1;

    // Single request from idle, release, turnaround, idle.
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    check("t1_gnt", gnt, 4'b0100);
    check("t1_oe", oe, 4'b0100);
    check("t1_owner", owner, 2);
    check("t1_busy", bus_busy, 1);
    req = 4'b0000;
    @(negedge clk);
    check("t1_turn_gnt", gnt, 0);
    check("t1_turn_busy", bus_busy, 0);
    @(negedge clk);
    check("t1_idle_busy", bus_busy, 0);
    check("t1_idle_owner", owner, 2);

    // All four request; each releases after three grant cycles.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("t2_gnt", gnt, 4'b0001 << k);
        if (c == 2) req = req & ~(4'b0001 << k);
      end
      @(negedge clk);
      check("t2_turn", gnt, 0);
    end
    @(negedge clk);

    // Hold timeout forces device 0 off after eight grant cycles.
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("t3_hold", gnt, 4'b0001);
      check("t3_no_preempt", preempt, 0);
      if (c == 3) req = 4'b0011;
    end
    @(negedge clk);
    check("t3_release", gnt, 0);
    check("t3_preempt", preempt, 1);
    @(negedge clk);
    check("t3_new_gnt", gnt, 4'b0010);
    check("t3_new_owner", owner, 1);
    check("t3_preempt_gone", preempt, 0);
    req = 4'b0001;
    @(negedge clk);
    check("t3_turn2", gnt, 0);
    @(negedge clk);
    check("t3_back_to_0", gnt, 4'b0001);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // A lone requester is never preempted.
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t4_hold", gnt, 4'b0001);
      check("t4_preempt", preempt, 0);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a tenure.
    req = 4'b0100;
    @(negedge clk);
    check("t5_gnt", gnt, 4'b0100);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_gnt", gnt, 0);
    check("t5_async_oe", oe, 0);
    check("t5_async_busy", bus_busy, 0);
    check("t5_async_owner", owner, 0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1010;
    @(negedge clk);
    check("t5_ptr_reset", gnt, 4'b0010);
    check("t5_owner", owner, 1);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // Random request traffic.
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 7) == 0) req = req ^ (4'b0001 << b);
      end
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
